i2c_c2t_link_arbiter: RTL

I2C_C2T_LINK_ARBITER -- requirements
Module: i2c_c2t_link_arbiter

---
 rtl/i2c_c2t_link_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/i2c_c2t_link_arbiter.sv
// Round-robin arbiter that serialises one requester's frame at a time onto the
// C2T differential link: START, FRAME_W data bits MSB first, then STOP.
module i2c_c2t_link_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FRAME_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*FRAME_W-1:0] req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       c2tp,
  output logic                       c2tn
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FRAME_W);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                    state, state_d;
  logic [PW-1:0]             ptr, ptr_d;
  logic [CW-1:0]             cnt, cnt_d;
  logic [FRAME_W-1:0]        shreg, shreg_d;
  logic [NUM_REQ-1:0]        gnt_d;
  logic                      busy_d, c2tp_d, c2tn_d;
  logic [NUM_REQ-1:0][FRAME_W-1:0] data_arr;
  logic [PW-1:0]             win_idx, idx;
  logic [PW:0]               sum;
  logic                      win_vld, launch;

  assign data_arr = req_data;

  // Search starts at ptr, which always holds last winner + 1.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    shreg_d = shreg;
    gnt_d   = '0;
    busy_d  = busy;
    c2tp_d  = c2tp;
    c2tn_d  = c2tn;
    launch  = 1'b0;
    case (state)
      IDLE:  launch = enable && win_vld;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        c2tp_d  = shreg[FRAME_W-1];
        c2tn_d  = ~shreg[FRAME_W-1];
        shreg_d = {shreg[FRAME_W-2:0], 1'b0};
      end
      DATA: begin
        if (cnt == CW'(FRAME_W-1)) begin
          state_d = STOP;
          c2tp_d  = 1'b0;
          c2tn_d  = 1'b1;
        end else begin
          cnt_d   = cnt + 1'b1;
          c2tp_d  = shreg[FRAME_W-1];
          c2tn_d  = ~shreg[FRAME_W-1];
          shreg_d = {shreg[FRAME_W-2:0], 1'b0};
        end
      end
      STOP: begin
        launch  = enable && win_vld;
        state_d = IDLE;
        busy_d  = 1'b0;
        c2tp_d  = 1'b0;
        c2tn_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Grant overrides the STOP->IDLE defaults so frames run back to back.
    if (launch) begin
      state_d = START;
      gnt_d   = NUM_REQ'(1) << win_idx;
      shreg_d = data_arr[win_idx];
      ptr_d   = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
      busy_d  = 1'b1;
      c2tp_d  = 1'b1;
      c2tn_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      shreg <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      c2tp  <= 1'b0;
      c2tn  <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
      shreg <= shreg_d;
      gnt   <= gnt_d;
      busy  <= busy_d;
      c2tp  <= c2tp_d;
      c2tn  <= c2tn_d;
    end
  end
endmodule
